// File: rtl/ps2_arrow_receiver.sv
// PS/2 device-to-host frame receiver with arrow-key make/break decoding.
// Handshake: code_valid is a one-cycle strobe (no ready); scan_code is stable from that cycle until the next strobe.
module ps2_arrow_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       btnUp,
  output logic       btnDown,
  output logic       btnLeft,
  output logic       btnRight
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_CHECK
  } state_t;

  logic          ps2_clk_s1_q, ps2_clk_s2_q;
  logic          ps2_data_s1_q, ps2_data_s2_q;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          code_valid_q, code_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          e0_q, e0_d;
  logic          f0_q, f0_d;
  logic          btn_up_q, btn_up_d;
  logic          btn_down_q, btn_down_d;
  logic          btn_left_q, btn_left_d;
  logic          btn_right_q, btn_right_d;
  logic          fall;

  always_comb begin
    filt_clk_d   = filt_clk_q;
    filt_cnt_d   = '0;
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tmo_cnt_d    = tmo_cnt_q;
    scan_code_d  = scan_code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    e0_d         = e0_q;
    f0_d         = f0_q;
    btn_up_d     = btn_up_q;
    btn_down_d   = btn_down_q;
    btn_left_d   = btn_left_q;
    btn_right_d  = btn_right_q;
    fall         = 1'b0;

    // The filtered clock flips only after FILTER_LEN samples in a row disagree with it.
    if (ps2_clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = ps2_clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
    fall = filt_clk_q & ~filt_clk_d;

    case (state_q)
      S_IDLE: begin
        tmo_cnt_d = '0;
        if (fall && !ps2_data_s2_q) begin
          state_d  = S_DATA;
          bitcnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d = {ps2_data_s2_q, shift_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (fall) begin
          parity_d = ps2_data_s2_q;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        // The verdict is registered on the stop edge so the strobe lands in the CHECK cycle.
        if (fall) begin
          state_d = S_CHECK;
          if ((^{shift_q, parity_q}) && ps2_data_s2_q) begin
            scan_code_d  = shift_q;
            code_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      S_CHECK: begin
        state_d  = S_IDLE;
        bitcnt_d = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP) begin
      if (fall) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q == TMO_LAST) begin
        tmo_cnt_d   = '0;
        frame_err_d = 1'b1;
        state_d     = S_IDLE;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end

    // Only E0-prefixed arrow codes move the buttons; keypad codes without E0 are ignored.
    if (code_valid_q) begin
      case (scan_code_q)
        8'hE0: e0_d = 1'b1;
        8'hF0: f0_d = 1'b1;
        default: begin
          if (e0_q) begin
            case (scan_code_q)
              8'h75:   btn_up_d    = ~f0_q;
              8'h72:   btn_down_d  = ~f0_q;
              8'h6B:   btn_left_d  = ~f0_q;
              8'h74:   btn_right_d = ~f0_q;
              default: ;
            endcase
          end
          e0_d = 1'b0;
          f0_d = 1'b0;
        end
      endcase
    end else if (frame_err_q) begin
      e0_d = 1'b0;
      f0_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps2_clk_s1_q  <= 1'b1;
      ps2_clk_s2_q  <= 1'b1;
      ps2_data_s1_q <= 1'b1;
      ps2_data_s2_q <= 1'b1;
      filt_clk_q    <= 1'b1;
      filt_cnt_q    <= '0;
      state_q       <= S_IDLE;
      bitcnt_q      <= 3'd0;
      shift_q       <= 8'h00;
      parity_q      <= 1'b0;
      tmo_cnt_q     <= '0;
      scan_code_q   <= 8'h00;
      code_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      e0_q          <= 1'b0;
      f0_q          <= 1'b0;
      btn_up_q      <= 1'b0;
      btn_down_q    <= 1'b0;
      btn_left_q    <= 1'b0;
      btn_right_q   <= 1'b0;
    end else begin
      ps2_clk_s1_q  <= ps2_clk;
      ps2_clk_s2_q  <= ps2_clk_s1_q;
      ps2_data_s1_q <= ps2_data;
      ps2_data_s2_q <= ps2_data_s1_q;
      filt_clk_q    <= filt_clk_d;
      filt_cnt_q    <= filt_cnt_d;
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      tmo_cnt_q     <= tmo_cnt_d;
      scan_code_q   <= scan_code_d;
      code_valid_q  <= code_valid_d;
      frame_err_q   <= frame_err_d;
      e0_q          <= e0_d;
      f0_q          <= f0_d;
      btn_up_q      <= btn_up_d;
      btn_down_q    <= btn_down_d;
      btn_left_q    <= btn_left_d;
      btn_right_q   <= btn_right_d;
    end
  end

  assign scan_code  = scan_code_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;
  assign btnUp      = btn_up_q;
  assign btnDown    = btn_down_q;
  assign btnLeft    = btn_left_q;
  assign btnRight   = btn_right_q;

endmodule

// File: tb/tb_ps2_arrow_receiver.sv
// Directed bench for ps2_arrow_receiver: drives PS/2 frames and checks bytes, errors and arrow levels.
module tb_ps2_arrow_receiver;

  localparam int HP = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;
  logic       btnUp, btnDown, btnLeft, btnRight;

  int n_cmp = 0;
  int n_mis = 0;
  int fe_cnt = 0;
  int fe_hi = 0;
  int both_cnt = 0;
  logic cv_prev = 1'b0;
  logic [7:0] got_q[$];
  logic [3:0] btn_q[$];

  ps2_arrow_receiver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .code_valid(code_valid),
    .frame_err (frame_err),
    .btnUp     (btnUp),
    .btnDown   (btnDown),
    .btnLeft   (btnLeft),
    .btnRight  (btnRight)
  );

  always #5 clk = ~clk;

  // Monitor: bytes on each strobe, button levels one cycle after each strobe, error pulses.
  always @(negedge clk) begin
    if (code_valid) got_q.push_back(scan_code);
    if (cv_prev) btn_q.push_back({btnUp, btnDown, btnLeft, btnRight});
    cv_prev = code_valid;
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (code_valid && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk);
    ps2_data = b;
    wait_cyc(HP);
    ps2_clk = 1'b0;
    wait_cyc(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_parity);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ flip_parity);
    send_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(HP);
  endtask

  task automatic expect_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input int n);
    logic [7:0] exp_q[$];
    exp_q = {e0, e1, e2};
    check_eq({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (got_q.size() > 0) check_eq({tag, "_byte"}, got_q.pop_front(), exp_q[i]);
    end
    got_q.delete();
  endtask

  task automatic check_btn_after(input string tag, input logic [3:0] exp);
    check_eq({tag, "_btn_q_nonempty"}, btn_q.size() > 0, 1);
    if (btn_q.size() > 0) check_eq(tag, btn_q[btn_q.size()-1], exp);
  endtask

  initial begin
    int fe0;
    int k;

    wait_cyc(5);
    @(negedge clk);
    check_eq("reset_outputs", {scan_code, code_valid, frame_err, btnUp, btnDown, btnLeft, btnRight}, 0);
    rst_n = 1'b1;
    wait_cyc(20);

    // Up arrow make
    fe0 = fe_cnt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    expect_bytes("up_make", 8'hE0, 8'h75, 8'h00, 2);
    check_btn_after("up_make_btn_next_cycle", 4'b1000);
    check_eq("up_make_no_err", fe_cnt - fe0, 0);

    // Up arrow break
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    expect_bytes("up_break", 8'hE0, 8'hF0, 8'h75, 3);
    check_btn_after("up_break_btn_next_cycle", 4'b0000);
    check_eq("up_break_no_err", fe_cnt - fe0, 0);

    // Bad parity on 6B
    send_frame(8'h6B, 1'b1);
    expect_bytes("bad_parity", 8'h00, 8'h00, 8'h00, 0);
    check_eq("bad_parity_err_pulses", fe_cnt - fe0, 1);
    check_eq("bad_parity_scan_kept", scan_code, 8'h75);
    check_eq("bad_parity_btns", {btnUp, btnDown, btnLeft, btnRight}, 4'b0000);

    // Short glitch while idle, then clean 1C
    fe0 = fe_cnt;
    @(posedge clk);
    ps2_clk = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b1;
    wait_cyc(30);
    send_frame(8'h1C, 1'b0);
    expect_bytes("glitch_1c", 8'h1C, 8'h00, 8'h00, 1);
    check_eq("glitch_no_err", fe_cnt - fe0, 0);
    check_eq("glitch_btns", {btnUp, btnDown, btnLeft, btnRight}, 4'b0000);

    // Partial frame then timeout
    fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    k = 0;
    while (fe_cnt == fe0 && k < 60000) begin
      @(posedge clk);
      k = k + 1;
    end
    wait_cyc(20);
    check_eq("timeout_err_pulses", fe_cnt - fe0, 1);
    check_eq("timeout_latency_window", (k >= 49800 && k <= 50000), 1);
    expect_bytes("timeout_no_byte", 8'h00, 8'h00, 8'h00, 0);

    // Right arrow make after timeout
    send_frame(8'hE0, 1'b0);
    send_frame(8'h74, 1'b0);
    expect_bytes("right_make", 8'hE0, 8'h74, 8'h00, 2);
    check_btn_after("right_make_btn_next_cycle", 4'b0001);

    // Down arrow make, then reset in the middle of a frame
    send_frame(8'hE0, 1'b0);
    send_frame(8'h72, 1'b0);
    expect_bytes("down_make", 8'hE0, 8'h72, 8'h00, 2);
    check_eq("down_and_right_held", {btnUp, btnDown, btnLeft, btnRight}, 4'b0101);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midframe_reset_outputs",
             {scan_code, code_valid, frame_err, btnUp, btnDown, btnLeft, btnRight}, 0);
    wait_cyc(3);
    rst_n = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(20);
    got_q.delete();
    fe0 = fe_cnt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h72, 1'b0);
    expect_bytes("down_after_reset", 8'hE0, 8'h72, 8'h00, 2);
    check_btn_after("down_after_reset_btn", 4'b0100);
    check_eq("down_after_reset_no_err", fe_cnt - fe0, 0);

    check_eq("valid_err_never_together", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
